// File: rtl/noc_pe_interface.sv
// Leaf network interface: frames PE payloads into flits for the router (four-phase TX)
// and accepts flits from the router into a small receive FIFO (four-phase RX).
module noc_pe_interface #(
    parameter int                    WIDTH       = 35,
    parameter int                    WIDTH_ADDR  = 3,
    parameter logic [WIDTH_ADDR-1:0] MY_ADDR     = 3'b000,
    parameter int                    PAYLOAD_W   = WIDTH - 2*WIDTH_ADDR,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    RX_DEPTH    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [WIDTH_ADDR-1:0] tx_dst,
    input  logic [PAYLOAD_W-1:0]  tx_payload,
    output logic                  out_req,
    input  logic                  out_ack,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  in_req,
    output logic                  in_ack,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [WIDTH_ADDR-1:0] rx_src,
    output logic [PAYLOAD_W-1:0]  rx_payload,
    output logic [7:0]            tx_count,
    output logic [7:0]            rx_count,
    output logic [7:0]            drop_count
);
    localparam int PTR_W   = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CNT_W   = $clog2(RX_DEPTH + 1);
    localparam int ENTRY_W = WIDTH_ADDR + PAYLOAD_W;

    // ---------------- handshake synchronisers ----------------
    logic [SYNC_STAGES-1:0] ack_sync_reg;
    logic [SYNC_STAGES-1:0] req_sync_reg;
    logic                   ack_s;
    logic                   req_s;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    ack_sync_reg[gi] <= 1'b0;
                    req_sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    ack_sync_reg[gi] <= out_ack;
                    req_sync_reg[gi] <= in_req;
                end else begin
                    ack_sync_reg[gi] <= ack_sync_reg[(gi > 0) ? gi-1 : 0];
                    req_sync_reg[gi] <= req_sync_reg[(gi > 0) ? gi-1 : 0];
                end
            end
        end
    endgenerate

    assign ack_s = ack_sync_reg[SYNC_STAGES-1];
    assign req_s = req_sync_reg[SYNC_STAGES-1];

    // ---------------- transmitter ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_REQ, TX_RELEASE} tx_state_t;
    tx_state_t        tx_state_reg, tx_state_next;
    logic             out_req_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             tx_accept;
    logic             tx_done;

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_accept     = 1'b0;
        tx_done       = 1'b0;
        case (tx_state_reg)
            TX_IDLE: if (tx_valid) begin
                tx_accept     = 1'b1;
                tx_state_next = TX_SETUP;
            end
            // Holding off while ack is still high keeps req from rising against a stale ack.
            TX_SETUP:   if (!ack_s) tx_state_next = TX_REQ;
            TX_REQ:     if (ack_s)  tx_state_next = TX_RELEASE;
            TX_RELEASE: if (!ack_s) begin
                tx_done       = 1'b1;
                tx_state_next = TX_IDLE;
            end
            default:    tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= TX_IDLE;
            out_req_reg  <= 1'b0;
            out_data_reg <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            out_req_reg  <= (tx_state_next == TX_REQ);
            if (tx_accept)
                out_data_reg <= {tx_dst, MY_ADDR, tx_payload};
        end
    end

    assign tx_ready = (tx_state_reg == TX_IDLE);
    assign out_req  = out_req_reg;
    assign out_data = out_data_reg;

    // ---------------- receiver ----------------
    typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;
    rx_state_t        rx_state_reg, rx_state_next;
    logic             in_ack_reg;
    logic [ENTRY_W-1:0] mem_reg [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] fill_reg;
    logic             full;
    logic             rx_take;
    logic             addr_match;
    logic             push;
    logic             drop;
    logic             pop;
    logic [ENTRY_W-1:0] head;

    // Fullness is judged on the registered count, so a same-cycle pop never frees room early.
    assign full       = (fill_reg == CNT_W'(RX_DEPTH));
    assign addr_match = (in_data[WIDTH-1 -: WIDTH_ADDR] == MY_ADDR);
    assign rx_take    = (rx_state_reg == RX_IDLE) && req_s && !full;
    assign push       = rx_take && addr_match;
    assign drop       = rx_take && !addr_match;
    assign rx_valid   = (fill_reg != '0);
    assign pop        = rx_valid && rx_ready;

    always_comb begin
        rx_state_next = rx_state_reg;
        case (rx_state_reg)
            RX_IDLE: if (rx_take) rx_state_next = RX_ACK;
            RX_ACK:  if (!req_s)  rx_state_next = RX_IDLE;
            default: rx_state_next = RX_IDLE;
        endcase
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RX_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg <= RX_IDLE;
            in_ack_reg   <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fill_reg     <= '0;
        end else begin
            rx_state_reg <= rx_state_next;
            in_ack_reg   <= (rx_state_next == RX_ACK);
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (push && !pop)
                fill_reg <= fill_reg + 1'b1;
            else if (pop && !push)
                fill_reg <= fill_reg - 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < RX_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst)
                    mem_reg[gi] <= '0;
                else if (push && wr_ptr_reg == PTR_W'(gi))
                    mem_reg[gi] <= {in_data[WIDTH-WIDTH_ADDR-1 -: WIDTH_ADDR], in_data[PAYLOAD_W-1:0]};
            end
        end
    endgenerate

    assign head       = mem_reg[rd_ptr_reg];
    assign rx_src     = head[ENTRY_W-1 -: WIDTH_ADDR];
    assign rx_payload = head[PAYLOAD_W-1:0];
    assign in_ack     = in_ack_reg;

    // ---------------- saturating event counters: 0=tx, 1=rx, 2=drop ----------------
    logic [2:0] cnt_inc;
    logic [7:0] cnt_reg [3];

    assign cnt_inc = {drop, push, tx_done};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst)
                    cnt_reg[gi] <= 8'd0;
                else if (cnt_inc[gi] && cnt_reg[gi] != 8'hFF)
                    cnt_reg[gi] <= cnt_reg[gi] + 8'd1;
            end
        end
    endgenerate

    assign tx_count   = cnt_reg[0];
    assign rx_count   = cnt_reg[1];
    assign drop_count = cnt_reg[2];

endmodule

// File: tb/tb_noc_pe_interface.sv
// Scoreboarded bench for noc_pe_interface: directed TX/RX handshakes, backpressure,
// misaddressed drop, counter saturation and mid-handshake reset.
module tb_noc_pe_interface;
    localparam int WIDTH = 35;
    localparam int WA    = 3;
    localparam int PW    = 29;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid;
    logic          tx_ready;
    logic [WA-1:0] tx_dst;
    logic [PW-1:0] tx_payload;
    logic          out_req;
    logic          out_ack;
    logic [WIDTH-1:0] out_data;
    logic          in_req;
    logic          in_ack;
    logic [WIDTH-1:0] in_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [WA-1:0] rx_src;
    logic [PW-1:0] rx_payload;
    logic [7:0]    tx_count;
    logic [7:0]    rx_count;
    logic [7:0]    drop_count;

    noc_pe_interface dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst(tx_dst), .tx_payload(tx_payload),
        .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
        .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src(rx_src), .rx_payload(rx_payload),
        .tx_count(tx_count), .rx_count(rx_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit router_en = 1'b0;
    logic [WIDTH-1:0]  tx_exp_q [$];
    logic [WA+PW-1:0]  rx_exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return tx_ready;
            1:       return in_ack;
            2:       return out_req;
            default: return rx_valid;
        endcase
    endfunction

    task automatic wait_cond(input string name, input int sel, input logic val, input int max);
        int n = 0;
        while (sig(sel) !== val && n < max) begin
            cyc();
            n++;
        end
        check(name, 64'(sig(sel)), 64'(val));
    endtask

    task automatic send_rx(input logic [WIDTH-1:0] flit);
        in_data = flit;
        in_req  = 1'b1;
        wait_cond("rx_ack_rise", 1, 1'b1, 20);
        in_req  = 1'b0;
        wait_cond("rx_ack_fall", 1, 1'b0, 20);
    endtask

    // Router model: acknowledges one cycle after req, returns to zero after req drops.
    initial begin
        out_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (router_en) begin
                if (out_req && !out_ack)
                    out_ack = 1'b1;
                else if (!out_req && out_ack)
                    out_ack = 1'b0;
            end
        end
    end

    // TX monitor: each rising out_req presents one flit.
    initial begin
        logic prev_req;
        logic [WIDTH-1:0] exp;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (out_req === 1'b1 && !prev_req) begin
                if (tx_exp_q.size() == 0) begin
                    check("tx_unexpected_flit", 64'(out_data), 64'h0);
                end else begin
                    exp = tx_exp_q.pop_front();
                    $display("TX flit %h expected %h", out_data, exp);
                    check("tx_flit", 64'(out_data), 64'(exp));
                end
            end
            prev_req = (out_req === 1'b1);
        end
    end

    // RX monitor: each rx_valid && rx_ready delivers one entry.
    initial begin
        logic [WA+PW-1:0] exp;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
                if (rx_exp_q.size() == 0) begin
                    check("rx_unexpected_entry", 64'({rx_src, rx_payload}), 64'h0);
                end else begin
                    exp = rx_exp_q.pop_front();
                    $display("RX src %0h payload %h expected %h", rx_src, rx_payload, exp);
                    check("rx_entry", 64'({rx_src, rx_payload}), 64'(exp));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [WIDTH-1:0] flit;
        rst = 1'b1; tx_valid = 1'b0; tx_dst = '0; tx_payload = '0;
        in_req = 1'b0; in_data = '0; rx_ready = 1'b0;
        repeat (3) cyc();
        check("rst_tx_ready",   64'(tx_ready),   64'd1);
        check("rst_out_req",    64'(out_req),    64'd0);
        check("rst_out_data",   64'(out_data),   64'd0);
        check("rst_in_ack",     64'(in_ack),     64'd0);
        check("rst_rx_valid",   64'(rx_valid),   64'd0);
        check("rst_rx_src",     64'(rx_src),     64'd0);
        check("rst_rx_payload", 64'(rx_payload), 64'd0);
        check("rst_tx_count",   64'(tx_count),   64'd0);
        check("rst_rx_count",   64'(rx_count),   64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        rst = 1'b0;
        router_en = 1'b1;
        cyc();

        // Single transmit with timing.
        flit = {3'b010, 3'b000, 29'h1ABCDEF};
        tx_exp_q.push_back(flit);
        tx_dst = 3'b010; tx_payload = 29'h1ABCDEF; tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        check("tx_setup_data",  64'(out_data), 64'(flit));
        check("tx_setup_req",   64'(out_req),  64'd0);
        check("tx_setup_ready", 64'(tx_ready), 64'd0);
        cyc();
        check("tx_req_high", 64'(out_req), 64'd1);
        wait_cond("tx_back_idle", 0, 1'b1, 30);
        check("tx_rtz_req",   64'(out_req),  64'd0);
        check("tx_data_hold", 64'(out_data), 64'(flit));
        check("tx_count_1",   64'(tx_count), 64'd1);

        // Single receive with latency.
        in_data = {3'b000, 3'b110, 29'h5};
        rx_exp_q.push_back({3'b110, 29'h5});
        in_req = 1'b1;
        cyc(); cyc();
        check("rx_ack_not_early", 64'(in_ack), 64'd0);
        cyc();
        check("rx_ack_3cyc",  64'(in_ack),     64'd1);
        check("rx_valid_1",   64'(rx_valid),   64'd1);
        check("rx_src_6",     64'(rx_src),     64'd6);
        check("rx_payload_5", 64'(rx_payload), 64'd5);
        in_req = 1'b0;
        wait_cond("rx_ack_fall", 1, 1'b0, 20);
        check("rx_count_1", 64'(rx_count), 64'd1);
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        check("rx_empty_after_pop", 64'(rx_valid), 64'd0);

        // Backpressure: two buffered, third waits until one is popped.
        rx_exp_q.push_back({3'b001, 29'h11});
        send_rx({3'b000, 3'b001, 29'h11});
        rx_exp_q.push_back({3'b010, 29'h22});
        send_rx({3'b000, 3'b010, 29'h22});
        rx_exp_q.push_back({3'b011, 29'h33});
        in_data = {3'b000, 3'b011, 29'h33};
        in_req = 1'b1;
        repeat (8) cyc();
        check("bp_no_ack",    64'(in_ack),   64'd0);
        check("bp_full_valid", 64'(rx_valid), 64'd1);
        check("bp_rx_count",  64'(rx_count), 64'd3);
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        wait_cond("bp_ack_after_pop", 1, 1'b1, 10);
        in_req = 1'b0;
        wait_cond("bp_ack_fall", 1, 1'b0, 20);
        check("bp_rx_count_4", 64'(rx_count), 64'd4);
        rx_ready = 1'b1;
        wait_cond("bp_drain", 3, 1'b0, 10);
        rx_ready = 1'b0;
        check("bp_queue_empty", 64'(rx_exp_q.size()), 64'd0);

        // Misaddressed flit is acknowledged and dropped.
        send_rx({3'b111, 3'b101, 29'h77});
        check("drop_rx_valid", 64'(rx_valid),   64'd0);
        check("drop_count_1",  64'(drop_count), 64'd1);
        check("drop_rx_count", 64'(rx_count),   64'd4);

        // Counter saturation over 260 more transmits.
        for (int i = 0; i < 260; i++) begin
            wait_cond("sat_tx_ready", 0, 1'b1, 30);
            tx_dst     = 3'(i);
            tx_payload = 29'(i * 3 + 1);
            tx_exp_q.push_back({3'(i), 3'b000, 29'(i * 3 + 1)});
            tx_valid = 1'b1;
            cyc();
            tx_valid = 1'b0;
        end
        wait_cond("sat_final_idle", 0, 1'b1, 30);
        check("tx_count_sat", 64'(tx_count), 64'd255);

        // Reset while both handshakes are mid-flight.
        router_en = 1'b0;
        tx_exp_q.push_back({3'b011, 3'b000, 29'h9});
        tx_dst = 3'b011; tx_payload = 29'h9; tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        in_data = {3'b000, 3'b100, 29'h44};
        in_req = 1'b1;
        wait_cond("mid_out_req", 2, 1'b1, 10);
        wait_cond("mid_in_ack",  1, 1'b1, 10);
        check("mid_rx_valid", 64'(rx_valid), 64'd1);
        rst = 1'b1;
        cyc();
        check("mid_rst_out_req",  64'(out_req),  64'd0);
        check("mid_rst_in_ack",   64'(in_ack),   64'd0);
        check("mid_rst_rx_valid", 64'(rx_valid), 64'd0);
        check("mid_rst_tx_ready", 64'(tx_ready), 64'd1);
        check("mid_rst_tx_count", 64'(tx_count), 64'd0);
        in_req = 1'b0;
        cyc();
        rst = 1'b0;
        router_en = 1'b1;
        repeat (4) cyc();
        check("end_tx_queue_empty", 64'(tx_exp_q.size()), 64'd0);
        check("end_rx_queue_empty", 64'(rx_exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
